// File: rtl/sprites_pkg.sv
// Shared types and constants for the bouncing_sprites renderer: colour palette,
// ball-update FSM states and the per-ball state record.
package sprites_pkg;

    // Wide enough for any supported resolution; the renderer clamps all maths to this.
    localparam int COORD_W = 12;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [7:0][8:0] PALETTE = {
        9'h0DB, 9'h1FF, 9'h007, 9'h038, 9'h1C0, 9'h1F8, 9'h1C7, 9'h03F
    };

    localparam logic signed [COORD_W:0] STEP_POS = 1;
    localparam logic signed [COORD_W:0] STEP_NEG = -1;

    typedef enum logic {
        IDLE,
        UPDATE
    } fsm_state_t;

    // Velocity is always +1 or -1, so only its sign is stored.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               dx_neg;
        logic               dy_neg;
        logic [2:0]         colour;
    } ball_t;

    // One motion step along one axis, one bit wider and signed so underflow shows as negative.
    function automatic logic signed [COORD_W:0] step_axis(input logic [COORD_W-1:0] pos,
                                                           input logic neg);
        return $signed({1'b0, pos}) + (neg ? STEP_NEG : STEP_POS);
    endfunction

endpackage

// File: rtl/raster_scan.sv
// Raster counter for bouncing_sprites: walks px/py in raster order, registers the linear
// pixel address and toggles swap at each frame wrap.
module raster_scan
    import sprites_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               frame_wrap,
    output logic               swap,
    output logic [ADDR_W-1:0]  address
);

    logic wrap_q;

    assign frame_wrap = (px == COORD_W'(H_RES - 1)) && (py == COORD_W'(V_RES - 1));

    // swap is delayed one cycle so it flips together with address 0 of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            px      <= '0;
            py      <= '0;
            wrap_q  <= 1'b0;
            swap    <= 1'b0;
            address <= '0;
        end else begin
            address <= ADDR_W'(py * H_RES + px);
            wrap_q  <= frame_wrap;
            swap    <= swap ^ wrap_q;
            if (px == COORD_W'(H_RES - 1)) begin
                px <= '0;
                py <= frame_wrap ? '0 : py + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bouncing_sprites.sv
// Multi-ball sprite renderer: raster scan plus a sequential per-ball bounce FSM with
// double-buffered display positions. Define BOUNCING_SPRITES_BORDER_EN for a white frame border.
module bouncing_sprites
    import sprites_pkg::*;
#(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int ADDR_W          = 19,
    parameter int NUM_BALLS       = 4,
    parameter int BALL_SIZE       = 10,
    parameter int FRAMES_PER_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              swap,
    output logic [8:0]        data,
    output logic [ADDR_W-1:0] address
);

    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int IDX_W  = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic signed [COORD_W:0] X_MAX = (COORD_W+1)'(H_RES - BALL_SIZE);
    localparam logic signed [COORD_W:0] Y_MAX = (COORD_W+1)'(V_RES - BALL_SIZE);

    logic [COORD_W-1:0] px, py;
    logic               frame_wrap;

    raster_scan #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_raster_scan (
        .clk        (clk),
        .rst        (rst),
        .px         (px),
        .py         (py),
        .frame_wrap (frame_wrap),
        .swap       (swap),
        .address    (address)
    );

    function automatic ball_t init_ball(input int i);
        ball_t b;
        int    xi;
        xi = (i + 1) * (H_RES / (NUM_BALLS + 1));
        if (xi > H_RES - BALL_SIZE) xi = H_RES - BALL_SIZE;
        b.x      = COORD_W'(xi);
        b.y      = COORD_W'(V_RES / 2);
        b.dx_neg = (i % 2) != 0;
        b.dy_neg = (i % 2) == 0;
        b.colour = 3'(i % 8);
        return b;
    endfunction

    ball_t              work [NUM_BALLS];
    ball_t              disp [NUM_BALLS];
    fsm_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [STEP_W-1:0]  step_cnt;
    logic               armed;

    ball_t                     cur, nxt;
    logic signed [COORD_W:0]   nx, ny;
    logic                      bounce_x, bounce_y;
    logic [8:0]                pixel;

    assign armed = frame_wrap && (step_cnt == STEP_W'(FRAMES_PER_STEP - 1));

    // Single shared adder: only the ball selected by idx is evaluated each cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur      = work[idx];
        nxt      = cur;
        nx       = step_axis(cur.x, cur.dx_neg);
        ny       = step_axis(cur.y, cur.dy_neg);
        bounce_x = nx[COORD_W] || (nx > X_MAX);
        bounce_y = ny[COORD_W] || (ny > Y_MAX);
        if (bounce_x) nxt.dx_neg = ~cur.dx_neg;
        else          nxt.x      = nx[COORD_W-1:0];
        if (bounce_y) nxt.dy_neg = ~cur.dy_neg;
        else          nxt.y      = ny[COORD_W-1:0];
        if (bounce_x || bounce_y) nxt.colour = cur.colour + 3'd1;
    end

    // Descending scan so the lowest-index covering ball is the last writer and wins.
    always_comb begin
        pixel = 9'h000;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (px >= disp[i].x && px <= disp[i].x + COORD_W'(BALL_SIZE - 1) &&
                py >= disp[i].y && py <= disp[i].y + COORD_W'(BALL_SIZE - 1))
                pixel = PALETTE[disp[i].colour];
        end
`ifdef BOUNCING_SPRITES_BORDER_EN
        if (px == '0 || px == COORD_W'(H_RES - 1) || py == '0 || py == COORD_W'(V_RES - 1))
            pixel = 9'h1FF;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data     <= 9'h000;
            state    <= IDLE;
            idx      <= '0;
            step_cnt <= '0;
            // NOTE: the ball arrays are small flop banks, not RAM, so resetting them is legal and
            // gives deterministic start positions.
            for (int i = 0; i < NUM_BALLS; i++) begin
                work[i] <= init_ball(i);
                disp[i] <= init_ball(i);
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            data <= pixel;
            if (frame_wrap) step_cnt <= armed ? '0 : step_cnt + 1'b1;
            if (armed) begin
                for (int i = 0; i < NUM_BALLS; i++) disp[i] <= work[i];
            end
            case (state)
                IDLE: begin
                    if (armed) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    work[idx] <= nxt;
                    if (idx == IDX_W'(NUM_BALLS - 1)) state <= IDLE;
                    else                              idx   <= idx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bouncing_sprites.sv
// Directed bench for bouncing_sprites: two small instances (per-frame steps, and a
// two-frame step with a corner double bounce) checked against hand-computed frames.
module tb_bouncing_sprites;

    localparam int HA = 16, VA = 8, NA = HA * VA;
    localparam int HB = 12, VB = 8, NB = HB * VB;
`ifdef BOUNCING_SPRITES_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam logic [8:0] PAL [8] = '{9'h03F, 9'h1C7, 9'h1F8, 9'h1C0,
                                       9'h038, 9'h007, 9'h1FF, 9'h0DB};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       swap_a, swap_b;
    logic [8:0] data_a, data_b;
    logic [6:0] address_a, address_b;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] pix_a [NA];
    logic [8:0] pix_b [NB];
    int         addr_err_a, addr_err_b, swap_chg_a;
    logic       swap0_a;

    bouncing_sprites #(
        .H_RES(HA), .V_RES(VA), .ADDR_W(7), .NUM_BALLS(2), .BALL_SIZE(2), .FRAMES_PER_STEP(1)
    ) dut_a (
        .clk(clk), .rst(rst), .swap(swap_a), .data(data_a), .address(address_a)
    );

    bouncing_sprites #(
        .H_RES(HB), .V_RES(VB), .ADDR_W(7), .NUM_BALLS(1), .BALL_SIZE(2), .FRAMES_PER_STEP(2)
    ) dut_b (
        .clk(clk), .rst(rst), .swap(swap_b), .data(data_b), .address(address_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit on_border(input int x, input int y, input int w, input int h);
        return BORDER && (x == 0 || x == w - 1 || y == 0 || y == h - 1);
    endfunction

    task automatic capture_a();
        addr_err_a = 0;
        swap_chg_a = 0;
        for (int a = 0; a < NA; a++) begin
            @(posedge clk);
            @(negedge clk);
            if (address_a != 7'(a)) addr_err_a++;
            pix_a[a] = data_a;
            if (a == 0) swap0_a = swap_a;
            else if (swap_a != swap0_a) swap_chg_a++;
        end
    endtask

    task automatic capture_b();
        addr_err_b = 0;
        for (int a = 0; a < NB; a++) begin
            @(posedge clk);
            @(negedge clk);
            if (address_b != 7'(a)) addr_err_b++;
            pix_b[a] = data_b;
        end
    endtask

    task automatic check_ball(input string tag, input bit on_b, input int x, input int y,
                              input int c);
        int         w, h, a;
        logic [8:0] got, exp;
        w = on_b ? HB : HA;
        h = on_b ? VB : VA;
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                a   = (y + oy) * w + x + ox;
                got = on_b ? pix_b[a] : pix_a[a];
                exp = on_border(x + ox, y + oy, w, h) ? 9'h1FF : PAL[c];
                check($sformatf("%s@%0d", tag, a), 32'(got), 32'(exp));
            end
        end
    endtask

    // Number of frame-A pixels that are not plain background.
    task automatic check_count_a(input string tag, input int exp);
        int n = 0;
        for (int a = 0; a < NA; a++) begin
            if (pix_a[a] != (on_border(a % HA, a / HA, HA, VA) ? 9'h1FF : 9'h000)) n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic frame_checks_a(input int f);
        case (f)
            0: begin
                check("a_f0_addr_seq", 32'(addr_err_a), 0);
                check("a_f0_swap", 32'(swap0_a), 0);
                check("a_f0_swap_stable", 32'(swap_chg_a), 0);
                check("a_f0_pix0", 32'(pix_a[0]), on_border(0, 0, HA, VA) ? 32'h1FF : 32'h0);
                check_ball("a_f0_b0", 1'b0, 5, 4, 0);
                check_ball("a_f0_b1", 1'b0, 10, 4, 1);
                check_count_a("a_f0_count", 8);
            end
            1: begin
                check("a_f1_addr_seq", 32'(addr_err_a), 0);
                check("a_f1_swap", 32'(swap0_a), 1);
                check("a_f1_swap_stable", 32'(swap_chg_a), 0);
                check_ball("a_f1_b0", 1'b0, 5, 4, 0);
            end
            2: begin
                check("a_f2_swap", 32'(swap0_a), 0);
                check_ball("a_f2_b0", 1'b0, 6, 3, 0);
                check_ball("a_f2_b1", 1'b0, 9, 5, 1);
            end
            3:  check_ball("a_f3_b0", 1'b0, 7, 2, 0);
            4:  check_ball("a_f4_b1_bottom", 1'b0, 7, 6, 2);
            6:  check_ball("a_f6_b0_top", 1'b0, 10, 0, 1);
            7:  check_ball("a_f7_b0", 1'b0, 11, 1, 1);
            11: begin
                check_ball("a_f11_b0_right", 1'b0, 14, 5, 2);
                check_ball("a_f11_b1", 1'b0, 0, 0, 3);
            end
            12: begin
                check_ball("a_f12_b0", 1'b0, 13, 6, 2);
                check_ball("a_f12_b1_left", 1'b0, 0, 1, 4);
            end
            default: ;
        endcase
    endtask

    task automatic frame_checks_b(input int f);
        case (f)
            0:  check("b_f0_addr_seq", 32'(addr_err_b), 0);
            1:  check_ball("b_f1", 1'b1, 6, 4, 0);
            3:  check_ball("b_f3_hold", 1'b1, 6, 4, 0);
            4:  check_ball("b_f4_step", 1'b1, 7, 3, 0);
            5:  check_ball("b_f5_hold", 1'b1, 7, 3, 0);
            12: check_ball("b_f12_corner", 1'b1, 10, 0, 1);
            14: check_ball("b_f14_after", 1'b1, 9, 1, 1);
            default: ;
        endcase
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_a", 32'(address_a), 0);
        check("rst_data_a", 32'(data_a), 0);
        check("rst_swap_a", 32'(swap_a), 0);
        rst = 1'b0;

        fork
            for (int f = 0; f < 13; f++) begin
                capture_a();
                frame_checks_a(f);
            end
            for (int f = 0; f < 15; f++) begin
                capture_b();
                frame_checks_b(f);
            end
        join

        // Land on the cycle just after an A frame wrap, while its update FSM is running.
        found = (address_a == 7'd127);
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = (address_a == 7'd127);
        end
        check("sync_to_wrap", 32'(found), 1);

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_addr_a", 32'(address_a), 0);
        check("mid_rst_data_a", 32'(data_a), 0);
        check("mid_rst_swap_a", 32'(swap_a), 0);
        check("mid_rst_addr_b", 32'(address_b), 0);
        check("mid_rst_data_b", 32'(data_b), 0);
        check("mid_rst_swap_b", 32'(swap_b), 0);
        rst = 1'b0;

        fork
            capture_a();
            capture_b();
        join
        check("post_rst_addr_seq_a", 32'(addr_err_a), 0);
        check("post_rst_addr_seq_b", 32'(addr_err_b), 0);
        check("post_rst_swap_a", 32'(swap0_a), 0);
        check("post_rst_pix0_a", 32'(pix_a[0]), on_border(0, 0, HA, VA) ? 32'h1FF : 32'h0);
        check_ball("post_rst_b0", 1'b0, 5, 4, 0);
        check_ball("post_rst_b1", 1'b0, 10, 4, 1);
        check_count_a("post_rst_count", 8);
        check_ball("post_rst_bb", 1'b1, 6, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
